// File: rtl/control_fsm_pkg.sv
// Shared RV32I control types: opcode map, write-back and next-PC selects,
// and the multicycle controller state encoding.
package control_fsm_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F,
    OPC_SYSTEM = 7'h73
  } rv32i_opcode_t;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_PCP4 = 2'd2
  } regfile_sel_t;

  typedef enum logic [1:0] {
    NOT_JUMPING   = 2'd0,
    JUMP_J_TYPE   = 2'd1,
    JUMP_I_TYPE   = 2'd2,
    BRANCH_B_TYPE = 2'd3
  } jump_type_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_EXEC_ALU,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_JUMP_J,
    S_JUMP_I,
    S_BRANCH,
    S_HALT,
    S_TRAP
  } ctrl_state_t;

endpackage

// File: rtl/control_decode.sv
// Maps the latched opcode to the state that follows DECODE; anything outside
// the supported RV32I subset lands in TRAP.
module control_decode
  import control_fsm_pkg::*;
(
  input  rv32i_opcode_t opcode,
  output ctrl_state_t   next_state
);

  always_comb begin
    next_state = S_TRAP;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: next_state = S_EXEC_ALU;
      OPC_LOAD:   next_state = S_MEM_RD;
      OPC_STORE:  next_state = S_MEM_WR;
      OPC_JAL:    next_state = S_JUMP_J;
      OPC_JALR:   next_state = S_JUMP_I;
      OPC_BRANCH: next_state = S_BRANCH;
      OPC_SYSTEM: next_state = S_HALT;
      default:    next_state = S_TRAP;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32I control unit: fetch/decode/execute sequencing, run gating,
// sticky halt/trap status and a retired-instruction counter.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  rv32i_opcode_t      opcode,
  input  logic               take_branch,
  output logic               regfile_wren,
  output logic               ir_wren,
  output logic               pc_inc,
  output logic               mem_wren,
  output logic               ram_raddr_31_20,
  output regfile_sel_t       regfile_sel_from_alu_mem_pcp4,
  output jump_type_t         jumping,
  output logic               halted,
  output logic               trap,
  output logic [WIDTH-1:0]   instret
);

  ctrl_state_t state;
  ctrl_state_t next_state;
  ctrl_state_t decode_next;
  logic        retire;

  control_decode u_decode (
    .opcode     (opcode),
    .next_state (decode_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      instret <= '0;
    end else begin
      state <= next_state;
      if (retire) instret <= instret + WIDTH'(1);
    end
  end

  // Outputs follow the state alone, except the branch PC enable.
  always_comb begin
    next_state                    = state;
    retire                        = 1'b0;
    regfile_wren                  = 1'b0;
    ir_wren                       = 1'b0;
    pc_inc                        = 1'b0;
    mem_wren                      = 1'b0;
    ram_raddr_31_20               = 1'b0;
    regfile_sel_from_alu_mem_pcp4 = SEL_ALU;
    jumping                       = NOT_JUMPING;
    halted                        = 1'b0;
    trap                          = 1'b0;

    case (state)
      S_IDLE:   if (run) next_state = S_FETCH;
      S_FETCH:  next_state = S_LATCH;
      S_LATCH: begin
        ir_wren    = 1'b1;
        pc_inc     = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: next_state = decode_next;
      S_EXEC_ALU: begin
        regfile_wren = 1'b1;
        retire       = 1'b1;
      end
      // Read data arrives one cycle after the address, so the address is held.
      S_MEM_RD: begin
        ram_raddr_31_20 = 1'b1;
        next_state      = S_MEM_WB;
      end
      S_MEM_WB: begin
        ram_raddr_31_20               = 1'b1;
        regfile_wren                  = 1'b1;
        regfile_sel_from_alu_mem_pcp4 = SEL_MEM;
        retire                        = 1'b1;
      end
      S_MEM_WR: begin
        ram_raddr_31_20 = 1'b1;
        mem_wren        = 1'b1;
        retire          = 1'b1;
      end
      S_JUMP_J: begin
        regfile_wren                  = 1'b1;
        regfile_sel_from_alu_mem_pcp4 = SEL_PCP4;
        pc_inc                        = 1'b1;
        jumping                       = JUMP_J_TYPE;
        retire                        = 1'b1;
      end
      S_JUMP_I: begin
        regfile_wren                  = 1'b1;
        regfile_sel_from_alu_mem_pcp4 = SEL_PCP4;
        pc_inc                        = 1'b1;
        jumping                       = JUMP_I_TYPE;
        retire                        = 1'b1;
      end
      S_BRANCH: begin
        jumping = BRANCH_B_TYPE;
        pc_inc  = take_branch;
        retire  = 1'b1;
      end
      S_HALT:   halted = 1'b1;
      S_TRAP:   trap   = 1'b1;
      default:  next_state = S_IDLE;
    endcase

    // run only matters at instruction boundaries.
    if (retire) next_state = run ? S_FETCH : S_IDLE;
  end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: instruction-level reference model pushes
// expected per-cycle control vectors, a negedge monitor pops and compares.
module tb_control_fsm;
  import control_fsm_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          take_branch;
  rv32i_opcode_t opcode;

  logic         regfile_wren, ir_wren, pc_inc, mem_wren, ram_raddr_31_20, halted, trap;
  regfile_sel_t wb_sel;
  jump_type_t   jumping;
  logic [31:0]  instret;

  logic         w_regfile_wren, w_ir_wren, w_pc_inc, w_mem_wren, w_ram_raddr, w_halted, w_trap;
  regfile_sel_t w_wb_sel;
  jump_type_t   w_jumping;
  logic [2:0]   w_instret;

  control_fsm #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .take_branch(take_branch),
    .regfile_wren(regfile_wren), .ir_wren(ir_wren), .pc_inc(pc_inc), .mem_wren(mem_wren),
    .ram_raddr_31_20(ram_raddr_31_20), .regfile_sel_from_alu_mem_pcp4(wb_sel),
    .jumping(jumping), .halted(halted), .trap(trap), .instret(instret)
  );

  // Narrow counter instance: wraps every 8 retirements.
  control_fsm #(.WIDTH(3)) u_wrap (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .take_branch(take_branch),
    .regfile_wren(w_regfile_wren), .ir_wren(w_ir_wren), .pc_inc(w_pc_inc), .mem_wren(w_mem_wren),
    .ram_raddr_31_20(w_ram_raddr), .regfile_sel_from_alu_mem_pcp4(w_wb_sel),
    .jumping(w_jumping), .halted(w_halted), .trap(w_trap), .instret(w_instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         rw;
    logic         irw;
    logic         pci;
    logic         mw;
    logic         ra;
    regfile_sel_t sel;
    jump_type_t   jmp;
    logic         hlt;
    logic         trp;
    logic [31:0]  cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_exp, mon_act, mon_wexp, mon_wact;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] model_cnt = '0;

  // Control vector of one named phase of an instruction.
  function automatic exp_t phase(input string k, input logic tkn);
    exp_t e;
    e     = '0;
    e.sel = SEL_ALU;
    e.jmp = NOT_JUMPING;
    e.cnt = model_cnt;
    case (k)
      "latch":  begin e.irw = 1'b1; e.pci = 1'b1; end
      "alu":    e.rw = 1'b1;
      "mem_rd": e.ra = 1'b1;
      "mem_wb": begin e.ra = 1'b1; e.rw = 1'b1; e.sel = SEL_MEM; end
      "store":  begin e.ra = 1'b1; e.mw = 1'b1; end
      "jal":    begin e.rw = 1'b1; e.sel = SEL_PCP4; e.pci = 1'b1; e.jmp = JUMP_J_TYPE; end
      "jalr":   begin e.rw = 1'b1; e.sel = SEL_PCP4; e.pci = 1'b1; e.jmp = JUMP_I_TYPE; end
      "branch": begin e.jmp = BRANCH_B_TYPE; e.pci = tkn; end
      "halt":   e.hlt = 1'b1;
      "trap":   e.trp = 1'b1;
      default:  ;
    endcase
    return e;
  endfunction

  task automatic push(input string k, input logic tkn = 1'b0);
    q.push_back(phase(k, tkn));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_exp = q.pop_front();
      mon_act = '{regfile_wren, ir_wren, pc_inc, mem_wren, ram_raddr_31_20,
                  wb_sel, jumping, halted, trap, instret};
      checks++;
      if (mon_act === mon_exp) passes++;
      else $display("FAIL outputs @%0t: actual=%h required=%h", $time, mon_act, mon_exp);
      mon_wexp     = mon_exp;
      mon_wexp.cnt = {29'd0, mon_exp.cnt[2:0]};
      mon_wact = '{w_regfile_wren, w_ir_wren, w_pc_inc, w_mem_wren, w_ram_raddr,
                   w_wb_sel, w_jumping, w_halted, w_trap, {29'd0, w_instret}};
      checks++;
      if (mon_wact === mon_wexp) passes++;
      else $display("FAIL wrap_outputs @%0t: actual=%h required=%h", $time, mon_wact, mon_wexp);
    end
  end

  // Called at posedge+1 with the DUT in FETCH.
  task automatic run_insn(input rv32i_opcode_t op, input logic tkn, input logic run_after);
    string body[$];
    opcode      = op;
    take_branch = tkn;
    run         = run_after;
    push("fetch"); push("latch"); push("decode");
    case (op)
      OPC_LOAD:   begin body.push_back("mem_rd"); body.push_back("mem_wb"); end
      OPC_STORE:  body.push_back("store");
      OPC_JAL:    body.push_back("jal");
      OPC_JALR:   body.push_back("jalr");
      OPC_BRANCH: body.push_back("branch");
      default:    body.push_back("alu");
    endcase
    foreach (body[i]) push(body[i], tkn);
    model_cnt = model_cnt + 32'd1;
    cycles(3 + body.size());
  endtask

  // Called at posedge+1 with the DUT in IDLE; leaves it in FETCH.
  task automatic idle_gap(input int k);
    run = 1'b0;
    repeat (k) push("idle");
    cycles(k);
    run = 1'b1;
    push("idle");
    cycles(1);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    run       = 1'b0;
    model_cnt = '0;
    push("idle"); push("idle");
    cycles(2);
    rst = 1'b1;
    idle_gap(0);
  endtask

  rv32i_opcode_t pool[9] = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD,
                             OPC_STORE, OPC_JAL, OPC_JALR, OPC_BRANCH};

  initial begin
    exp_t act, req;
    logic ra;
    rst = 1'b0; run = 1'b0; take_branch = 1'b0; opcode = OPC_OP;
    cycles(1);
    repeat (3) push("idle");
    cycles(3);
    rst = 1'b1;
    repeat (3) push("idle");
    cycles(3);
    idle_gap(0);

    run_insn(OPC_OP_IMM, 1'b0, 1'b1);
    run_insn(OPC_LOAD,   1'b0, 1'b1);
    run_insn(OPC_BRANCH, 1'b1, 1'b1);
    run_insn(OPC_BRANCH, 1'b0, 1'b1);
    run_insn(OPC_JAL,    1'b0, 1'b1);
    run_insn(OPC_JALR,   1'b0, 1'b1);
    run_insn(OPC_STORE,  1'b0, 1'b1);
    run_insn(OPC_OP,     1'b0, 1'b0);
    idle_gap(2);

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 3) != 0);
      run_insn(pool[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), ra);
      if (!ra) idle_gap($urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of EXEC_ALU.
    opcode = OPC_OP; run = 1'b1;
    push("fetch"); push("latch"); push("decode"); push("alu");
    cycles(3);
    #5;
    rst       = 1'b0;
    model_cnt = '0;
    #1;
    act = '{regfile_wren, ir_wren, pc_inc, mem_wren, ram_raddr_31_20,
            wb_sel, jumping, halted, trap, instret};
    req = phase("idle", 1'b0);
    checks++;
    if (act === req) passes++;
    else $display("FAIL async_reset: actual=%h required=%h", act, req);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_gap(0);
    run_insn(OPC_LUI, 1'b0, 1'b1);

    opcode = OPC_SYSTEM;
    push("fetch"); push("latch"); push("decode");
    repeat (10) push("halt");
    cycles(13);
    do_reset();

    opcode = rv32i_opcode_t'(7'h7F);
    push("fetch"); push("latch"); push("decode");
    repeat (4) push("trap");
    cycles(7);
    do_reset();
    run_insn(OPC_AUIPC, 1'b0, 1'b1);

    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL queue_drained: actual=%0d required=0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=%0t required<200000", $time);
    $fatal(1);
  end

endmodule
